// File: rtl/occupancy_grid_updater.sv
// Occupancy-grid store: a 2^(X_BITS+Y_BITS) array of signed log-odds cells updated by a
// two-stage saturating read-modify-write, with a hardware clear sweep and a query port.
module occupancy_grid_updater #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int CELL_WIDTH = 8,
  parameter int HIT_INC    = 1,
  parameter int MISS_DEC   = 1,
  parameter int CELL_MAX   = 127,
  parameter int CELL_MIN   = -127
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic                         clear_done,
  input  logic                         upd_valid,
  output logic                         upd_ready,
  input  logic [X_BITS-1:0]            upd_x,
  input  logic [Y_BITS-1:0]            upd_y,
  input  logic                         upd_free,
  input  logic                         qry_valid,
  output logic                         qry_ready,
  input  logic [X_BITS-1:0]            qry_x,
  input  logic [Y_BITS-1:0]            qry_y,
  output logic                         qry_data_valid,
  output logic signed [CELL_WIDTH-1:0] qry_data
);

  localparam int ADDR_W = X_BITS + Y_BITS;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int EXT_W  = CELL_WIDTH + 1;

  typedef logic [ADDR_W-1:0]            addr_t;
  typedef logic signed [CELL_WIDTH-1:0] cell_t;
  typedef logic signed [EXT_W-1:0]      ext_t;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  localparam addr_t LAST_ADDR = '1;
  localparam ext_t  HIT_EXT   = ext_t'(HIT_INC);
  localparam ext_t  MISS_EXT  = ext_t'(MISS_DEC);
  localparam ext_t  MAX_EXT   = ext_t'(CELL_MAX);
  localparam ext_t  MIN_EXT   = ext_t'(CELL_MIN);

  if (HIT_INC < 1 || HIT_INC > CELL_MAX || MISS_DEC < 1 || MISS_DEC > CELL_MAX) begin : g_bad_step
    $error("HIT_INC/MISS_DEC must lie in 1..CELL_MAX");
  end
  if (CELL_MIN < -((1 << (CELL_WIDTH - 1)) - 1) || CELL_MAX > ((1 << (CELL_WIDTH - 1)) - 1)) begin : g_bad_clamp
    $error("CELL_MIN/CELL_MAX exceed the cell range");
  end

  // ---------------------------------------------------------------------------
  // Control FSM and clear sweep
  // ---------------------------------------------------------------------------
  state_t state_q;
  addr_t  clr_cnt_q;
  logic   clear_done_q;

  // The transition edge is also the edge on which any stage-1 update writes, and
  // upd_ready is already low, so the pipeline is empty when the sweep begins.
  // NOTE: all sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (clear_start) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q      <= ST_IDLE;
            clear_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + addr_t'(1);
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = clear_done_q;

  // ---------------------------------------------------------------------------
  // Handshake: updates own the read port whenever they are offered
  // ---------------------------------------------------------------------------
  logic upd_fire;
  logic qry_fire;

  assign upd_ready = ~reset & (state_q == ST_IDLE) & ~clear_start;
  assign qry_ready = upd_ready & ~upd_valid;
  assign upd_fire  = upd_valid & upd_ready;
  assign qry_fire  = qry_valid & qry_ready;

  // ---------------------------------------------------------------------------
  // Cell RAM: one synchronous read, one write, read-during-write returns old data
  // ---------------------------------------------------------------------------
  cell_t mem [DEPTH];
  cell_t rd_data_q;
  addr_t rd_addr;
  logic  rd_en;
  logic  wr_en;
  addr_t wr_addr;
  cell_t wr_data;

  assign rd_en   = upd_fire | qry_fire;
  assign rd_addr = upd_fire ? {upd_y, upd_x} : {qry_y, qry_x};

  // NOTE: the array and its read register carry no reset; the clear sweep is the
  // only initialisation, which keeps the storage mappable onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Update stage 1, query stage 1 and write-forwarding registers
  // ---------------------------------------------------------------------------
  logic  s1_valid_q;
  addr_t s1_addr_q;
  logic  s1_free_q;
  logic  q1_valid_q;
  addr_t q1_addr_q;
  logic  fw_valid_q;
  addr_t fw_addr_q;
  cell_t fw_data_q;
  logic  qry_data_valid_q;
  cell_t qry_data_q;

  cell_t s1_old;
  ext_t  old_ext;
  ext_t  sum_ext;
  ext_t  diff_ext;
  cell_t upd_new_d;
  cell_t qry_data_d;

  // The read issued on the previous edge cannot see a write landing on that same
  // edge, so the last write is replayed from the forwarding registers.
  // NOTE: every combinational output gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    s1_old   = (fw_valid_q && fw_addr_q == s1_addr_q) ? fw_data_q : rd_data_q;
    old_ext  = ext_t'(s1_old);
    sum_ext  = old_ext + HIT_EXT;
    diff_ext = old_ext - MISS_EXT;
    if (s1_free_q) begin
      upd_new_d = (diff_ext < MIN_EXT) ? cell_t'(MIN_EXT) : cell_t'(diff_ext);
    end else begin
      upd_new_d = (sum_ext > MAX_EXT) ? cell_t'(MAX_EXT) : cell_t'(sum_ext);
    end
    qry_data_d = (fw_valid_q && fw_addr_q == q1_addr_q) ? fw_data_q : rd_data_q;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s1_addr_q;
    wr_data = upd_new_d;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_q;
        wr_data = '0;
      end else begin
        wr_en = s1_valid_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q       <= 1'b0;
      s1_addr_q        <= '0;
      s1_free_q        <= 1'b0;
      q1_valid_q       <= 1'b0;
      q1_addr_q        <= '0;
      fw_valid_q       <= 1'b0;
      fw_addr_q        <= '0;
      fw_data_q        <= '0;
      qry_data_valid_q <= 1'b0;
      qry_data_q       <= '0;
    end else begin
      s1_valid_q       <= upd_fire;
      q1_valid_q       <= qry_fire;
      fw_valid_q       <= wr_en;
      fw_addr_q        <= wr_addr;
      fw_data_q        <= wr_data;
      qry_data_valid_q <= q1_valid_q;
      if (upd_fire) begin
        s1_addr_q <= {upd_y, upd_x};
        s1_free_q <= upd_free;
      end
      if (qry_fire) q1_addr_q <= {qry_y, qry_x};
      if (q1_valid_q) qry_data_q <= qry_data_d;
    end
  end

  assign qry_data_valid = qry_data_valid_q;
  assign qry_data       = qry_data_q;

endmodule

// File: tb/tb_occupancy_grid_updater.sv
// Directed bench: instance A uses default parameters, instance B a 16x64 grid with
// HIT_INC=3 so short sweeps and non-unit increments can be exercised.
module tb_occupancy_grid_updater;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A (defaults)
  logic              a_rst = 1'b1, a_clear_start = 1'b0;
  logic              a_clear_busy, a_clear_done;
  logic              a_upd_valid = 1'b0, a_upd_ready, a_upd_free = 1'b0;
  logic [7:0]        a_upd_x = '0, a_qry_x = '0;
  logic [6:0]        a_upd_y = '0, a_qry_y = '0;
  logic              a_qry_valid = 1'b0, a_qry_ready, a_qdv;
  logic signed [7:0] a_qd;

  occupancy_grid_updater u_a (
    .clock(clk), .reset(a_rst), .clear_start(a_clear_start),
    .clear_busy(a_clear_busy), .clear_done(a_clear_done),
    .upd_valid(a_upd_valid), .upd_ready(a_upd_ready), .upd_x(a_upd_x), .upd_y(a_upd_y),
    .upd_free(a_upd_free), .qry_valid(a_qry_valid), .qry_ready(a_qry_ready),
    .qry_x(a_qry_x), .qry_y(a_qry_y), .qry_data_valid(a_qdv), .qry_data(a_qd)
  );

  // Instance B (16 x 64, hit +3, miss -1)
  logic              b_rst = 1'b1, b_clear_start = 1'b0;
  logic              b_clear_busy, b_clear_done;
  logic              b_upd_valid = 1'b0, b_upd_ready, b_upd_free = 1'b0;
  logic [3:0]        b_upd_x = '0, b_qry_x = '0;
  logic [5:0]        b_upd_y = '0, b_qry_y = '0;
  logic              b_qry_valid = 1'b0, b_qry_ready, b_qdv;
  logic signed [7:0] b_qd;

  occupancy_grid_updater #(.X_BITS(4), .Y_BITS(6), .HIT_INC(3), .MISS_DEC(1)) u_b (
    .clock(clk), .reset(b_rst), .clear_start(b_clear_start),
    .clear_busy(b_clear_busy), .clear_done(b_clear_done),
    .upd_valid(b_upd_valid), .upd_ready(b_upd_ready), .upd_x(b_upd_x), .upd_y(b_upd_y),
    .upd_free(b_upd_free), .qry_valid(b_qry_valid), .qry_ready(b_qry_ready),
    .qry_x(b_qry_x), .qry_y(b_qry_y), .qry_data_valid(b_qdv), .qry_data(b_qd)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_updates(input logic [7:0] x, input logic [6:0] y, input logic fr,
                           input int n, output int acc);
    acc = 0;
    a_upd_valid = 1'b1; a_upd_x = x; a_upd_y = y; a_upd_free = fr;
    for (int i = 0; i < n; i++) begin
      #1;
      if (a_upd_ready === 1'b1) acc++;
      @(posedge clk);
      #1;
    end
    a_upd_valid = 1'b0;
  endtask

  // ok is set only when the query is accepted and the result arrives exactly one cycle later.
  task automatic a_query(input logic [7:0] x, input logic [6:0] y,
                         output int val, output logic ok);
    a_qry_valid = 1'b1; a_qry_x = x; a_qry_y = y;
    #1;
    ok = (a_qry_ready === 1'b1);
    tick();
    a_qry_valid = 1'b0;
    ok = ok & (a_qdv === 1'b0);
    tick();
    ok = ok & (a_qdv === 1'b1);
    val = int'(a_qd);
  endtask

  task automatic b_seq(input logic [3:0] x, input logic [5:0] y, input logic [63:0] frees,
                       input int n, output int acc);
    acc = 0;
    b_upd_valid = 1'b1; b_upd_x = x; b_upd_y = y;
    for (int i = 0; i < n; i++) begin
      b_upd_free = frees[i];
      #1;
      if (b_upd_ready === 1'b1) acc++;
      @(posedge clk);
      #1;
    end
    b_upd_valid = 1'b0;
  endtask

  task automatic b_query(input logic [3:0] x, input logic [5:0] y,
                         output int val, output logic ok);
    b_qry_valid = 1'b1; b_qry_x = x; b_qry_y = y;
    #1;
    ok = (b_qry_ready === 1'b1);
    tick();
    b_qry_valid = 1'b0;
    ok = ok & (b_qdv === 1'b0);
    tick();
    ok = ok & (b_qdv === 1'b1);
    val = int'(b_qd);
  endtask

  task automatic test_reset();
    int cycles, dones, rdy, v;
    logic ok;
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (a_clear_busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b want 1", a_clear_busy); end
    n_cmp++; if (a_upd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_upd_ready got %b want 0", a_upd_ready); end
    n_cmp++; if (a_qry_ready !== 1'b0) begin n_bad++; $display("FAIL reset_qry_ready got %b want 0", a_qry_ready); end
    n_cmp++; if (a_clear_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", a_clear_done); end
    n_cmp++; if (a_qdv !== 1'b0 || a_qd !== 8'sd0) begin n_bad++; $display("FAIL reset_qry got valid=%b data=%0d want 0/0", a_qdv, a_qd); end
    a_rst = 1'b0; b_rst = 1'b0;
    cycles = 0; dones = 0; rdy = 0;
    while (a_clear_busy === 1'b1 && cycles < 40000) begin
      tick();
      cycles++;
      if (a_clear_done === 1'b1) dones++;
      if (a_clear_busy === 1'b1 && a_upd_ready === 1'b1) rdy++;
    end
    n_cmp++; if (cycles != 32768) begin n_bad++; $display("FAIL reset_sweep_len got %0d want 32768", cycles); end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL reset_done_count got %0d want 1", dones); end
    n_cmp++; if (rdy != 0) begin n_bad++; $display("FAIL reset_ready_during_sweep got %0d want 0", rdy); end
    tick();
    n_cmp++; if (a_clear_done !== 1'b0) begin n_bad++; $display("FAIL reset_done_pulse got %b want 0", a_clear_done); end
    n_cmp++; if (a_upd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_upd_ready got %b want 1", a_upd_ready); end
    a_query(8'd5, 7'd3, v, ok);
    n_cmp++; if (!ok || v != 0) begin n_bad++; $display("FAIL query_after_clear got ok=%b val=%0d want 1/0", ok, v); end
  endtask

  task automatic test_saturation();
    int acc, v;
    logic ok;
    a_updates(8'd200, 7'd100, 1'b0, 3, acc);
    a_query(8'd200, 7'd100, v, ok);
    n_cmp++; if (!ok || v != 3) begin n_bad++; $display("FAIL three_hits got ok=%b val=%0d want 1/3", ok, v); end
    a_updates(8'd10, 7'd20, 1'b0, 130, acc);
    n_cmp++; if (acc != 130) begin n_bad++; $display("FAIL hit_accepts got %0d want 130", acc); end
    a_query(8'd10, 7'd20, v, ok);
    n_cmp++; if (!ok || v != 127) begin n_bad++; $display("FAIL hit_saturate got ok=%b val=%0d want 1/127", ok, v); end
    a_updates(8'd10, 7'd20, 1'b1, 1, acc);
    a_query(8'd10, 7'd20, v, ok);
    n_cmp++; if (!ok || v != 126) begin n_bad++; $display("FAIL miss_from_max got ok=%b val=%0d want 1/126", ok, v); end
    a_updates(8'd10, 7'd20, 1'b1, 300, acc);
    n_cmp++; if (acc != 300) begin n_bad++; $display("FAIL miss_accepts got %0d want 300", acc); end
    a_query(8'd10, 7'd20, v, ok);
    n_cmp++; if (!ok || v != -127) begin n_bad++; $display("FAIL miss_saturate got ok=%b val=%0d want 1/-127", ok, v); end
    a_updates(8'd10, 7'd20, 1'b0, 1, acc);
    a_query(8'd10, 7'd20, v, ok);
    n_cmp++; if (!ok || v != -126) begin n_bad++; $display("FAIL hit_from_min got ok=%b val=%0d want 1/-126", ok, v); end
  endtask

  task automatic test_update_then_query();
    a_upd_valid = 1'b1; a_upd_x = 8'd1; a_upd_y = 7'd1; a_upd_free = 1'b0;
    a_qry_valid = 1'b1; a_qry_x = 8'd1; a_qry_y = 7'd1;
    #1;
    n_cmp++; if (a_qry_ready !== 1'b0) begin n_bad++; $display("FAIL priority_qry_ready got %b want 0", a_qry_ready); end
    n_cmp++; if (a_upd_ready !== 1'b1) begin n_bad++; $display("FAIL priority_upd_ready got %b want 1", a_upd_ready); end
    tick();
    a_upd_valid = 1'b0;
    #1;
    n_cmp++; if (a_qry_ready !== 1'b1) begin n_bad++; $display("FAIL qry_ready_after got %b want 1", a_qry_ready); end
    tick();
    a_qry_valid = 1'b0;
    n_cmp++; if (a_qdv !== 1'b0) begin n_bad++; $display("FAIL blocked_query_valid got %b want 0", a_qdv); end
    tick();
    n_cmp++; if (a_qdv !== 1'b1 || a_qd !== 8'sd1) begin n_bad++; $display("FAIL fwd_query got valid=%b data=%0d want 1/1", a_qdv, a_qd); end
    tick();
    n_cmp++; if (a_qdv !== 1'b0 || a_qd !== 8'sd1) begin n_bad++; $display("FAIL qry_hold got valid=%b data=%0d want 0/1", a_qdv, a_qd); end
  endtask

  task automatic test_forwarding();
    int acc, v;
    logic ok;
    b_seq(4'd2, 6'd3, 64'b010, 3, acc);
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL alt_accepts got %0d want 3", acc); end
    b_query(4'd2, 6'd3, v, ok);
    n_cmp++; if (!ok || v != 5) begin n_bad++; $display("FAIL alt_hit_miss_hit got ok=%b val=%0d want 1/5", ok, v); end
    b_seq(4'd7, 6'd9, 64'b00, 2, acc);
    b_query(4'd7, 6'd9, v, ok);
    n_cmp++; if (!ok || v != 6) begin n_bad++; $display("FAIL two_hits got ok=%b val=%0d want 1/6", ok, v); end
    b_seq(4'd4, 6'd4, 64'b11, 2, acc);
    b_query(4'd4, 6'd4, v, ok);
    n_cmp++; if (!ok || v != -2) begin n_bad++; $display("FAIL two_misses got ok=%b val=%0d want 1/-2", ok, v); end
    b_seq(4'd11, 6'd12, 64'b0, 42, acc);
    b_query(4'd11, 6'd12, v, ok);
    n_cmp++; if (!ok || v != 126) begin n_bad++; $display("FAIL hits_42 got ok=%b val=%0d want 1/126", ok, v); end
    b_seq(4'd9, 6'd9, 64'b0, 43, acc);
    b_query(4'd9, 6'd9, v, ok);
    n_cmp++; if (!ok || v != 127) begin n_bad++; $display("FAIL hits_43_clamp got ok=%b val=%0d want 1/127", ok, v); end
  endtask

  task automatic test_clear_during_stream();
    int acc, cycles, dones, rdy, v;
    logic ok;
    int px[5] = '{3, 0, 15, 9, 2};
    int py[5] = '{5, 0, 63, 9, 3};
    acc = 0;
    b_upd_valid = 1'b1; b_upd_x = 4'd3; b_upd_y = 6'd5; b_upd_free = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (b_upd_ready === 1'b1) acc++;
      tick();
    end
    b_clear_start = 1'b1;
    #1;
    n_cmp++; if (b_upd_ready !== 1'b0) begin n_bad++; $display("FAIL clear_req_ready got %b want 0", b_upd_ready); end
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL stream_accepts got %0d want 3", acc); end
    tick();
    b_clear_start = 1'b0;
    n_cmp++; if (b_clear_busy !== 1'b1) begin n_bad++; $display("FAIL clear_entry_busy got %b want 1", b_clear_busy); end
    cycles = 0; dones = 0; rdy = 0;
    while (b_clear_busy === 1'b1 && cycles < 2000) begin
      b_clear_start = (cycles == 100);
      tick();
      cycles++;
      if (b_clear_done === 1'b1) dones++;
      if (b_clear_busy === 1'b1 && b_upd_ready === 1'b1) rdy++;
    end
    b_upd_valid = 1'b0;
    b_clear_start = 1'b0;
    n_cmp++; if (cycles != 1024) begin n_bad++; $display("FAIL clear_sweep_len got %0d want 1024", cycles); end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL clear_done_count got %0d want 1", dones); end
    n_cmp++; if (rdy != 0) begin n_bad++; $display("FAIL clear_ready_during_sweep got %0d want 0", rdy); end
    for (int i = 0; i < 5; i++) begin
      b_query(4'(px[i]), 6'(py[i]), v, ok);
      n_cmp++;
      if (!ok || v != 0) begin
        n_bad++; $display("FAIL cleared_cell(%0d,%0d) got ok=%b val=%0d want 1/0", px[i], py[i], ok, v);
      end
    end
  endtask

  task automatic test_mid_sweep_reset();
    int cycles, dones, early_done, drops;
    b_clear_start = 1'b1;
    tick();
    b_clear_start = 1'b0;
    early_done = 0; drops = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (b_clear_done === 1'b1) early_done++;
      if (b_clear_busy !== 1'b1) drops++;
    end
    n_cmp++; if (early_done != 0 || drops != 0) begin n_bad++; $display("FAIL pre_reset_sweep got done=%0d drops=%0d want 0/0", early_done, drops); end
    b_rst = 1'b1;
    tick();
    n_cmp++; if (b_clear_busy !== 1'b1 || b_upd_ready !== 1'b0 || b_clear_done !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_state got busy=%b ready=%b done=%b want 1/0/0", b_clear_busy, b_upd_ready, b_clear_done);
    end
    b_rst = 1'b0;
    cycles = 0; dones = 0;
    while (b_clear_busy === 1'b1 && cycles < 2000) begin
      tick();
      cycles++;
      if (b_clear_done === 1'b1) dones++;
    end
    n_cmp++; if (cycles != 1024) begin n_bad++; $display("FAIL restart_sweep_len got %0d want 1024", cycles); end
    n_cmp++; if (dones != 1 || b_clear_done !== 1'b1) begin n_bad++; $display("FAIL restart_done got count=%0d last=%b want 1/1", dones, b_clear_done); end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_update_then_query();
    test_forwarding();
    test_clear_during_stream();
    test_mid_sweep_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
